regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the CPU datapath. It has a configurable register width, register count and number of combinational read ports, plus one synchronous write port with same-cycle write-to-read bypass. A per-register busy bit (scoreboard) is set at issue and cleared at writeback, so the decode stage can detect RAW hazards without its own tracking. Register 0 is hard-wired to zero and is never busy.

---
 rtl/regfile_scoreboard.sv | 75 +++++++
 tb/tb_regfile_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write bypass and per-register busy scoreboard
// Entry 0 has no storage: it reads as zero and can never be marked busy.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_nxt;
  logic [NREGS-1:0] busy_v;
  logic [AW:0]      cnt_nxt;

  assign busy_v = {busy_q, 1'b0};

  // Reserve beats flush, which beats the writeback clear.
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (rsv_en && rsv_addr == AW'(r))
        busy_nxt[r] = 1'b1;
      else if (flush)
        busy_nxt[r] = 1'b0;
      else if (we && wa == AW'(r))
        busy_nxt[r] = 1'b0;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 1; r < NREGS; r++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++)
        regs[r] <= '0;
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      if (we && wa != '0)
        regs[wa] <= wd;
      busy_q   <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // A register being written this cycle is forwarded and reported not busy.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = ra[i*AW +: AW];
    assign hit = we && (wa == a);
    assign rd[i*XLEN +: XLEN] = (!rst_n || a == '0) ? '0 :
                                hit ? wd : regs[a];
    assign rbusy[i] = rst_n && (a != '0) && !hit && busy_v[a];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and randomized checks of regfile_scoreboard
// Instance a uses default parameters; instance b uses XLEN=16, NREGS=8, NREAD=3.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic [1:0]  rbusy_a;
  logic        we_a, rsv_en_a, flush_a;
  logic [4:0]  wa_a, rsv_addr_a;
  logic [31:0] wd_a;
  logic [5:0]  cnt_a;

  logic [8:0]  ra_b;
  logic [47:0] rd_b;
  logic [2:0]  rbusy_b;
  logic        we_b, rsv_en_b, flush_b;
  logic [2:0]  wa_b, rsv_addr_b;
  logic [15:0] wd_b;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] mr [8];
  bit          mbz [8];

  regfile_scoreboard u_a (
    .clk(clk), .rst_n(rst_n), .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
    .we(we_a), .wa(wa_a), .wd(wd_a), .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a),
    .flush(flush_a), .busy_cnt(cnt_a)
  );

  regfile_scoreboard #(.XLEN(16), .NREGS(8), .NREAD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
    .we(we_b), .wa(wa_b), .wd(wd_b), .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b),
    .flush(flush_b), .busy_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++) begin
      mr[r]  = '0;
      mbz[r] = 1'b0;
    end
  endtask

  // Reference update for instance b at the coming edge, then step past it.
  task automatic tick();
    if (rst_n) begin
      if (we_b && wa_b != 0) mr[wa_b] = wd_b;
      if (we_b) mbz[wa_b] = 1'b0;
      if (flush_b) for (int r = 0; r < 8; r++) mbz[r] = 1'b0;
      if (rsv_en_b) mbz[rsv_addr_b] = 1'b1;
      mbz[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_rd_b(input logic [2:0] a);
    if (a == 0) return 16'h0;
    if (we_b && wa_b == a) return wd_b;
    return mr[a];
  endfunction

  function automatic logic exp_busy_b(input logic [2:0] a);
    if (a == 0) return 1'b0;
    if (we_b && wa_b == a) return 1'b0;
    return mbz[a];
  endfunction

  function automatic logic [3:0] exp_cnt_b();
    int n = 0;
    for (int r = 1; r < 8; r++) n += int'(mbz[r]);
    return 4'(n);
  endfunction

  initial begin
    rst_n = 1'b0;
    ra_a = '0; we_a = 0; wa_a = '0; wd_a = '0; rsv_en_a = 0; rsv_addr_a = '0; flush_a = 0;
    ra_b = '0; we_b = 0; wa_b = '0; wd_b = '0; rsv_en_b = 0; rsv_addr_b = '0; flush_b = 0;
    model_clear();
    #1;
    chk("reset_rd_a", rd_a, 64'h0);
    chk("reset_rbusy_a", rbusy_a, 2'b00);
    chk("reset_cnt_a", cnt_a, 6'd0);
    chk("reset_cnt_b", cnt_b, 4'd0);
    #12 rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-cycle wipes data and busy state.
    we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF;
    tick();
    we_a = 0; rsv_en_a = 1; rsv_addr_a = 5;
    tick();
    rsv_en_a = 0; ra_a = {5'd0, 5'd5};
    #1;
    chk("pre_reset_rd", rd_a[31:0], 32'hDEADBEEF);
    chk("pre_reset_busy", rbusy_a[0], 1'b1);
    chk("pre_reset_cnt", cnt_a, 6'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_rd", rd_a[31:0], 32'h0);
    chk("async_reset_busy", rbusy_a[0], 1'b0);
    chk("async_reset_cnt", cnt_a, 6'd0);
    #2 rst_n = 1'b1;
    model_clear();
    tick();
    chk("post_reset_rd", rd_a[31:0], 32'h0);
    chk("post_reset_busy", rbusy_a[0], 1'b0);

    // Register 0 ignores writes and reserves.
    we_a = 1; wa_a = 0; wd_a = 32'hFFFFFFFF; rsv_en_a = 1; rsv_addr_a = 0; ra_a = '0;
    #1;
    chk("x0_rd_same", rd_a, 64'h0);
    chk("x0_busy_same", rbusy_a, 2'b00);
    tick();
    we_a = 0; rsv_en_a = 0;
    #1;
    chk("x0_rd_next", rd_a, 64'h0);
    chk("x0_busy_next", rbusy_a, 2'b00);
    chk("x0_cnt", cnt_a, 6'd0);

    // Same-cycle bypass on both ports.
    we_a = 1; wa_a = 3; wd_a = 32'h11;
    tick();
    wd_a = 32'h22; ra_a = {5'd3, 5'd3};
    #1;
    chk("bypass_rd0", rd_a[31:0], 32'h22);
    chk("bypass_rd1", rd_a[63:32], 32'h22);
    tick();
    we_a = 0;
    #1;
    chk("bypass_next", rd_a[31:0], 32'h22);

    // Reserve then writeback round trip.
    rsv_en_a = 1; rsv_addr_a = 7; ra_a = {5'd0, 5'd7};
    tick();
    rsv_en_a = 0;
    #1;
    chk("rt_busy", rbusy_a[0], 1'b1);
    chk("rt_cnt", cnt_a, 6'd1);
    we_a = 1; wa_a = 7; wd_a = 32'h55;
    #1;
    chk("rt_wb_busy", rbusy_a[0], 1'b0);
    chk("rt_wb_rd", rd_a[31:0], 32'h55);
    tick();
    we_a = 0;
    #1;
    chk("rt_cnt_after", cnt_a, 6'd0);
    chk("rt_busy_after", rbusy_a[0], 1'b0);

    // Reserve wins over a same-cycle writeback.
    rsv_en_a = 1; rsv_addr_a = 9;
    tick();
    we_a = 1; wa_a = 9; wd_a = 32'h99;
    tick();
    we_a = 0; rsv_en_a = 0; ra_a = {5'd0, 5'd9};
    #1;
    chk("sim_wr_data", rd_a[31:0], 32'h99);
    chk("sim_wr_busy", rbusy_a[0], 1'b1);
    chk("sim_wr_cnt", cnt_a, 6'd1);

    // Reserve wins over a same-cycle flush.
    rsv_en_a = 1; rsv_addr_a = 2;
    tick();
    rsv_addr_a = 6;
    tick();
    chk("pre_flush_cnt", cnt_a, 6'd3);
    flush_a = 1; rsv_addr_a = 4;
    tick();
    flush_a = 0; rsv_en_a = 0;
    ra_a = {5'd2, 5'd4};
    #1;
    chk("flush_r4_busy", rbusy_a[0], 1'b1);
    chk("flush_r2_busy", rbusy_a[1], 1'b0);
    ra_a = {5'd9, 5'd6};
    #1;
    chk("flush_r6_busy", rbusy_a[0], 1'b0);
    chk("flush_r9_busy", rbusy_a[1], 1'b0);
    chk("flush_cnt", cnt_a, 6'd1);

    // Small configuration: fill, drain, then random traffic.
    for (int r = 1; r < 8; r++) begin
      rsv_en_b = 1; rsv_addr_b = 3'(r);
      tick();
    end
    rsv_en_b = 0;
    chk("b_fill_cnt", cnt_b, 4'd7);
    for (int r = 1; r < 8; r++) begin
      we_b = 1; wa_b = 3'(r); wd_b = 16'hA000 + 16'(r * 16'h0111);
      tick();
    end
    we_b = 0;
    chk("b_drain_cnt", cnt_b, 4'd0);
    chk("b_drain_model", cnt_b, exp_cnt_b());

    for (int c = 0; c < 1000; c++) begin
      ra_b       = 9'($urandom);
      we_b       = 1'($urandom);
      wa_b       = 3'($urandom);
      wd_b       = 16'($urandom);
      rsv_en_b   = 1'($urandom);
      rsv_addr_b = 3'($urandom);
      flush_b    = ($urandom_range(15) == 0);
      #1;
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("b_rd%0d_c%0d", p, c), rd_b[p*16 +: 16], exp_rd_b(ra_b[p*3 +: 3]));
        chk($sformatf("b_busy%0d_c%0d", p, c), rbusy_b[p], exp_busy_b(ra_b[p*3 +: 3]));
      end
      tick();
      chk($sformatf("b_cnt_c%0d", c), cnt_b, exp_cnt_b());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
